// File: rtl/spi_fpga_pkg.sv
// spi_fpga_pkg: shared state encoding, SPI mode helpers and counter sizing
// for the SPI_FPGA master/slave pair.
package spi_fpga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ACTIVE       = 2'd1,
        ST_WAIT_CS_HIGH = 2'd2
    } spi_state_e;

    // SCLK idle level and which edge carries the data sample
    localparam logic CPOL_IDLE_LOW       = 1'b0;
    localparam logic CPOL_IDLE_HIGH      = 1'b1;
    localparam logic CPHA_SAMPLE_LEADING = 1'b0;
    localparam logic CPHA_SAMPLE_TRAIL   = 1'b1;

    // Bit counter must hold 0..PACK_LENGTH inclusive
    function automatic int unsigned cnt_width(input int unsigned pack_len);
        return $clog2(pack_len + 1);
    endfunction

    function automatic logic lead_is_rise(input logic cpol);
        return (cpol == CPOL_IDLE_LOW);
    endfunction

    function automatic logic sample_on_lead(input logic cpha);
        return (cpha == CPHA_SAMPLE_LEADING);
    endfunction

endpackage

// File: rtl/spi_fpga_sync_edge.sv
// spi_fpga_sync_edge: two-flop synchroniser plus one history flop, giving a
// stable level and single-cycle rise/fall strobes in the local clock domain.
module spi_fpga_sync_edge #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
            prev_q <= RESET_VALUE;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_fpga_slave.sv
// spi_fpga_slave: oversampled full-duplex SPI slave running in IN_CLOCK.
// Returns the holding register on MISO and presents each received pack in parallel.
module spi_fpga_slave
    import spi_fpga_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY            = 50000000,
    parameter int unsigned BIT_PER_SECOND             = 12500000,
    parameter int unsigned PACK_LENGTH                = 8,
    parameter logic        CPOL                       = 1'b0,
    parameter logic        CPHA                       = 1'b0,
    parameter int unsigned PACK_BIT_SEQUENCE_TRANSMIT = 1,
    parameter int unsigned PACK_BIT_SEQUENCE_RECEIVE  = 1
) (
    input  logic                   IN_CLOCK,
    input  logic                   IN_RESET,
    input  logic                   IN_SCLK,
    input  logic                   IN_CS,
    input  logic                   IN_MOSI,
    input  logic [PACK_LENGTH-1:0] IN_TX_DATA,
    input  logic                   IN_TX_LOAD,
    output logic                   OUT_MISO,
    output logic                   OUT_MISO_OE,
    output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
    output logic                   OUT_RECEIVE_VALID,
    output logic                   OUT_TX_TAKEN,
    output logic                   OUT_FRAME_ERROR,
    output logic                   OUT_BUSY
);

    localparam int unsigned CW = cnt_width(PACK_LENGTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(PACK_LENGTH - 1);
    localparam logic TX_MSB = (PACK_BIT_SEQUENCE_TRANSMIT != 0);
    localparam logic RX_MSB = (PACK_BIT_SEQUENCE_RECEIVE != 0);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_fpga_sync_edge #(.RESET_VALUE(CPOL)) u_sync_sclk (
        .clk_i   (IN_CLOCK),
        .rst_i   (IN_RESET),
        .din_i   (IN_SCLK),
        .level_o (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_fpga_sync_edge #(.RESET_VALUE(1'b1)) u_sync_cs (
        .clk_i   (IN_CLOCK),
        .rst_i   (IN_RESET),
        .din_i   (IN_CS),
        .level_o (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_fpga_sync_edge #(.RESET_VALUE(1'b0)) u_sync_mosi (
        .clk_i   (IN_CLOCK),
        .rst_i   (IN_RESET),
        .din_i   (IN_MOSI),
        .level_o (mosi_lvl),
        .rise_o  (mosi_rise),
        .fall_o  (mosi_fall)
    );

    // Rate parameters constrain the master side; kept for interface parity
    logic unused_sigs;
    assign unused_sigs = sclk_lvl ^ mosi_rise ^ mosi_fall
                       ^ (CLOCK_FREQUENCY >= 4 * BIT_PER_SECOND);

    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = lead_is_rise(CPOL) ? sclk_rise : sclk_fall;
    assign trail_edge  = lead_is_rise(CPOL) ? sclk_fall : sclk_rise;
    assign sample_edge = sample_on_lead(CPHA) ? lead_edge : trail_edge;
    assign shift_edge  = sample_on_lead(CPHA) ? trail_edge : lead_edge;

    spi_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [PACK_LENGTH-1:0] rx_q, rx_d;
    logic [PACK_LENGTH-1:0] tx_q, tx_d;
    logic [PACK_LENGTH-1:0] hold_q, hold_d;
    logic [PACK_LENGTH-1:0] rdata_q, rdata_d;
    logic                   valid_q, valid_d;
    logic                   taken_q, taken_d;
    logic                   ferr_q, ferr_d;
    logic                   reload_q, reload_d;
    logic                   skip_q, skip_d;
    logic [1:0]             settle_q, settle_d;

    logic [PACK_LENGTH-1:0] rx_shift;
    logic [PACK_LENGTH-1:0] tx_adv;

    assign hold_d = IN_TX_LOAD ? IN_TX_DATA : hold_q;

    assign rx_shift = RX_MSB ? {rx_q[PACK_LENGTH-2:0], mosi_lvl}
                             : {mosi_lvl, rx_q[PACK_LENGTH-1:1]};
    assign tx_adv   = TX_MSB ? {tx_q[PACK_LENGTH-2:0], 1'b0}
                             : {1'b0, tx_q[PACK_LENGTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        rdata_d  = rdata_q;
        valid_d  = 1'b0;
        taken_d  = 1'b0;
        ferr_d   = 1'b0;
        reload_d = reload_q;
        skip_d   = skip_q;
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;

        unique case (state_q)
            ST_IDLE: begin
                tx_d     = hold_d;
                rx_d     = '0;
                cnt_d    = '0;
                reload_d = 1'b0;
                skip_d   = ~sample_on_lead(CPHA);
                // Synchroniser output is only trustworthy once its flops refill after reset
                if (settle_q != 2'd3) begin
                    if (settle_q == 2'd2 && !cs_lvl) begin
                        state_d = ST_WAIT_CS_HIGH;
                    end
                end else if (cs_fall) begin
                    state_d = ST_ACTIVE;
                    taken_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (sample_edge) begin
                    rx_d = rx_shift;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d    = '0;
                        rdata_d  = rx_shift;
                        valid_d  = 1'b1;
                        reload_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (shift_edge) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (reload_q) begin
                        tx_d     = hold_d;
                        reload_d = 1'b0;
                        taken_d  = 1'b1;
                    end else begin
                        tx_d = tx_adv;
                    end
                end
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    ferr_d  = (cnt_d != '0);
                end
            end
            ST_WAIT_CS_HIGH: begin
                if (cs_lvl) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge IN_CLOCK or posedge IN_RESET) begin
        if (IN_RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            hold_q   <= '0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            ferr_q   <= 1'b0;
            reload_q <= 1'b0;
            skip_q   <= 1'b0;
            settle_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            hold_q   <= hold_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            taken_q  <= taken_d;
            ferr_q   <= ferr_d;
            reload_q <= reload_d;
            skip_q   <= skip_d;
            settle_q <= settle_d;
        end
    end

    assign OUT_MISO          = TX_MSB ? tx_q[PACK_LENGTH-1] : tx_q[0];
    assign OUT_MISO_OE       = ~IN_CS & ~IN_RESET;
    assign OUT_RECEIVE_DATA  = rdata_q;
    assign OUT_RECEIVE_VALID = valid_q;
    assign OUT_TX_TAKEN      = taken_q;
    assign OUT_FRAME_ERROR   = ferr_q;
    assign OUT_BUSY          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_fpga_slave.sv
// tb_spi_fpga_slave: two slaves (mode 0 MSB-first, mode 3 LSB-first) driven by
// a behavioural SPI master; received and returned packs checked against the bench's own data.
module tb_spi_fpga_slave;

    localparam int PL = 8;
    // index 0: CPOL0/CPHA0 MSB-first, index 1: CPOL1/CPHA1 LSB-first
    localparam bit [1:0] CPOL_V = 2'b10;
    localparam bit [1:0] CPHA_V = 2'b10;
    localparam bit [1:0] TMSB_V = 2'b01;
    localparam bit [1:0] RMSB_V = 2'b01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sclk    [2];
    logic          cs      [2];
    logic          mosi    [2];
    logic          tx_load [2];
    logic [PL-1:0] tx_data [2];
    logic          miso    [2];
    logic          oe      [2];
    logic [PL-1:0] rdata   [2];
    logic          valid   [2];
    logic          taken   [2];
    logic          ferr    [2];
    logic          busy    [2];

    spi_fpga_slave #(
        .CLOCK_FREQUENCY(50000000), .BIT_PER_SECOND(12500000), .PACK_LENGTH(PL),
        .CPOL(1'b0), .CPHA(1'b0),
        .PACK_BIT_SEQUENCE_TRANSMIT(1), .PACK_BIT_SEQUENCE_RECEIVE(1)
    ) u_m0 (
        .IN_CLOCK(clk), .IN_RESET(rst), .IN_SCLK(sclk[0]), .IN_CS(cs[0]),
        .IN_MOSI(mosi[0]), .IN_TX_DATA(tx_data[0]), .IN_TX_LOAD(tx_load[0]),
        .OUT_MISO(miso[0]), .OUT_MISO_OE(oe[0]), .OUT_RECEIVE_DATA(rdata[0]),
        .OUT_RECEIVE_VALID(valid[0]), .OUT_TX_TAKEN(taken[0]),
        .OUT_FRAME_ERROR(ferr[0]), .OUT_BUSY(busy[0])
    );

    spi_fpga_slave #(
        .CLOCK_FREQUENCY(50000000), .BIT_PER_SECOND(12500000), .PACK_LENGTH(PL),
        .CPOL(1'b1), .CPHA(1'b1),
        .PACK_BIT_SEQUENCE_TRANSMIT(0), .PACK_BIT_SEQUENCE_RECEIVE(0)
    ) u_m3 (
        .IN_CLOCK(clk), .IN_RESET(rst), .IN_SCLK(sclk[1]), .IN_CS(cs[1]),
        .IN_MOSI(mosi[1]), .IN_TX_DATA(tx_data[1]), .IN_TX_LOAD(tx_load[1]),
        .OUT_MISO(miso[1]), .OUT_MISO_OE(oe[1]), .OUT_RECEIVE_DATA(rdata[1]),
        .OUT_RECEIVE_VALID(valid[1]), .OUT_TX_TAKEN(taken[1]),
        .OUT_FRAME_ERROR(ferr[1]), .OUT_BUSY(busy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt [2];
    int tcnt [2];
    int fcnt [2];
    logic [PL-1:0] rxq0 [$];
    logic [PL-1:0] rxq1 [$];

    always @(posedge clk) begin
        #1;
        if (valid[0]) rxq0.push_back(rdata[0]);
        if (valid[1]) rxq1.push_back(rdata[1]);
        for (int d = 0; d < 2; d++) begin
            vcnt[d] += int'(valid[d]);
            tcnt[d] += int'(taken[d]);
            fcnt[d] += int'(ferr[d]);
        end
    end

    typedef struct {
        int            d;
        logic [PL-1:0] mo;
        logic [PL-1:0] tv;
        logic [PL-1:0] exp_rx;
        logic [PL-1:0] exp_mi;
    } vec_t;

    vec_t          tbl [6];
    logic [PL-1:0] fr_mo [4];
    logic [PL-1:0] fr_tv [4];
    logic [PL-1:0] fr_mi [4];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rx(input int d, input string nm, input logic [PL-1:0] exp);
        logic [PL-1:0] got;
        bit have;
        have = 1'b0;
        got = '0;
        if (d == 0 && rxq0.size() > 0) begin have = 1'b1; got = rxq0.pop_front(); end
        if (d == 1 && rxq1.size() > 0) begin have = 1'b1; got = rxq1.pop_front(); end
        n_tests++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s: no receive pulse, expected data %02h", nm, exp);
        end else if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, got, exp);
        end
    endtask

    task automatic load(input int d, input logic [PL-1:0] v);
        tx_data[d] = v;
        tx_load[d] = 1'b1;
        tick(1);
        tx_load[d] = 1'b0;
    endtask

    // One pack as a master would clock it, half-period of 2 system clocks
    task automatic xfer(input int d, input logic [PL-1:0] mo, input int nbits,
                        input bit ld, input logic [PL-1:0] ldv,
                        output logic [PL-1:0] mi);
        mi = '0;
        for (int b = 0; b < nbits; b++) begin
            mosi[d] = RMSB_V[d] ? mo[PL-1-b] : mo[b];
            if (ld && b == 4) begin
                tx_data[d] = ldv;
                tx_load[d] = 1'b1;
            end
            if (!CPHA_V[d]) begin
                tick(1);
                tx_load[d] = 1'b0;
                sclk[d] = ~CPOL_V[d];
                tick(2);
                if (TMSB_V[d]) mi[PL-1-b] = miso[d]; else mi[b] = miso[d];
                sclk[d] = CPOL_V[d];
                tick(1);
            end else begin
                sclk[d] = ~CPOL_V[d];
                tick(1);
                tx_load[d] = 1'b0;
                tick(1);
                sclk[d] = CPOL_V[d];
                tick(2);
                if (TMSB_V[d]) mi[PL-1-b] = miso[d]; else mi[b] = miso[d];
            end
        end
    endtask

    task automatic frame(input int d, input int n);
        load(d, fr_tv[0]);
        cs[d] = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) begin
            xfer(d, fr_mo[i], PL, (i + 1 < n), fr_tv[(i + 1) % 4], fr_mi[i]);
        end
        tick(2);
        cs[d] = 1'b1;
        tick(6);
    endtask

    initial begin
        int v0, t0, f0, left, n;
        logic [PL-1:0] junk;

        tbl[0] = '{0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        tbl[1] = '{1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        tbl[2] = '{1, 8'h7E, 8'h81, 8'h7E, 8'h81};
        tbl[3] = '{0, 8'h00, 8'hFF, 8'h00, 8'hFF};
        tbl[4] = '{0, 8'hFF, 8'h00, 8'hFF, 8'h00};
        tbl[5] = '{1, 8'h01, 8'h80, 8'h01, 8'h80};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            sclk[d] = CPOL_V[d];
            cs[d] = 1'b1;
            mosi[d] = 1'b0;
            tx_load[d] = 1'b0;
            tx_data[d] = '0;
            vcnt[d] = 0;
            tcnt[d] = 0;
            fcnt[d] = 0;
        end
        tick(3);
        check("rst_busy", busy[0], 0);
        check("rst_valid", valid[0], 0);
        check("rst_rdata", rdata[0], 0);
        check("rst_miso", miso[0], 0);
        check("rst_oe", oe[1], 0);
        check("rst_taken", taken[1], 0);
        check("rst_ferr", ferr[0], 0);
        rst = 1'b0;
        tick(6);
        check("idle_busy0", busy[0], 0);
        check("idle_busy1", busy[1], 0);

        // First MISO bit must be present before CS falls
        load(0, 8'h80); tick(2); check("pre_miso_msb1", miso[0], 1);
        load(0, 8'h7F); tick(2); check("pre_miso_msb0", miso[0], 0);
        load(1, 8'h01); tick(2); check("pre_miso_lsb1", miso[1], 1);
        load(1, 8'hFE); tick(2); check("pre_miso_lsb0", miso[1], 0);

        for (int k = 0; k < 6; k++) begin
            fr_mo[0] = tbl[k].mo;
            fr_tv[0] = tbl[k].tv;
            v0 = vcnt[tbl[k].d];
            frame(tbl[k].d, 1);
            chk_rx(tbl[k].d, "tbl_rx", tbl[k].exp_rx);
            check("tbl_miso", fr_mi[0], tbl[k].exp_mi);
            check("tbl_nvalid", vcnt[tbl[k].d] - v0, 1);
        end

        // Two packs under one CS, new hold value loaded after the first take
        fr_mo[0] = 8'h12; fr_mo[1] = 8'hE7;
        fr_tv[0] = 8'h3C; fr_tv[1] = 8'h55;
        v0 = vcnt[0]; t0 = tcnt[0];
        frame(0, 2);
        chk_rx(0, "b2b_rx0", 8'h12);
        chk_rx(0, "b2b_rx1", 8'hE7);
        check("b2b_miso0", fr_mi[0], 8'h3C);
        check("b2b_miso1", fr_mi[1], 8'h55);
        check("b2b_nvalid", vcnt[0] - v0, 2);
        check("b2b_ntaken", tcnt[0] - t0, 3);

        // CS raised after three bits
        for (int d = 0; d < 2; d++) begin
            v0 = vcnt[d]; f0 = fcnt[d];
            load(d, 8'h99);
            cs[d] = 1'b0;
            tick(4);
            xfer(d, 8'hF0, 3, 1'b0, 8'h00, junk);
            tick(2);
            cs[d] = 1'b1;
            tick(6);
            check("ferr_count", fcnt[d] - f0, 1);
            check("ferr_novalid", vcnt[d] - v0, 0);
            fr_mo[0] = 8'h5A; fr_tv[0] = 8'hC3;
            frame(d, 1);
            chk_rx(d, "ferr_next_rx", 8'h5A);
            check("ferr_next_miso", fr_mi[0], 8'hC3);
        end

        // Reset in the middle of a pack with CS held low
        load(0, 8'hF1);
        cs[0] = 1'b0;
        tick(4);
        xfer(0, 8'hAA, 4, 1'b0, 8'h00, junk);
        rst = 1'b1;
        tick(2);
        check("mrst_busy", busy[0], 0);
        check("mrst_rdata", rdata[0], 0);
        check("mrst_miso", miso[0], 0);
        check("mrst_oe", oe[0], 0);
        sclk[0] = CPOL_V[0];
        tick(2);
        rst = 1'b0;
        tick(6);
        check("mrst_wait_busy", busy[0], 1);
        check("mrst_other_busy", busy[1], 0);
        check("mrst_oe_low_cs", oe[0], 1);
        v0 = vcnt[0];
        xfer(0, 8'h6B, PL, 1'b0, 8'h00, junk);
        tick(6);
        check("mrst_ignore_valid", vcnt[0] - v0, 0);
        check("mrst_still_busy", busy[0], 1);
        cs[0] = 1'b1;
        tick(6);
        check("mrst_release_busy", busy[0], 0);
        fr_mo[0] = 8'hA5; fr_tv[0] = 8'h3C;
        frame(0, 1);
        chk_rx(0, "mrst_next_rx", 8'hA5);
        check("mrst_next_miso", fr_mi[0], 8'h3C);
        check("rxq0_empty", rxq0.size(), 0);
        check("rxq1_empty", rxq1.size(), 0);

        // Random packs in frames of 1..4
        for (int d = 0; d < 2; d++) begin
            left = (d == 0) ? 256 : 64;
            while (left > 0) begin
                n = int'($urandom_range(4, 1));
                if (n > left) n = left;
                for (int i = 0; i < 4; i++) begin
                    fr_mo[i] = PL'($urandom);
                    fr_tv[i] = PL'($urandom);
                end
                frame(d, n);
                for (int i = 0; i < n; i++) begin
                    chk_rx(d, "rnd_rx", fr_mo[i]);
                    check("rnd_miso", fr_mi[i], fr_tv[i]);
                end
                left -= n;
            end
        end
        check("rnd_rxq0_empty", rxq0.size(), 0);
        check("rnd_rxq1_empty", rxq1.size(), 0);
        check("rnd_no_ferr0", fcnt[0], 1);
        check("rnd_no_ferr1", fcnt[1], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
